alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle shift-add multiplier sequencer that borrows the EX-stage ALU adder.
//  It sits between the EX-stage operand muxes and the ALU.
//  While idle, it passes pipeline operands straight through to the ALU.
//  While multiplying, it takes ownership of the ALU, drives one ADD per cycle and
//  stalls the pipeline. It produces the low XLEN bits of the product (RV32 MUL).
// PARAMETERS
//  XLEN    32       operand/result width
//  CNT_W   6        step counter width; must hold XLEN
//  ADD_OP  4'b0000  aluop code that selects op1+op2 in the ALU
// PORTS
//  clk         in   1     single clock, rising edge
//  rst_n       in   1     synchronous, active-low reset
//  start       in   1     request a multiply; sampled only in IDLE
//  mul_a       in   XLEN  multiplicand, captured on accepted start
//  mul_b       in   XLEN  multiplier, captured on accepted start
//  ex_op1      in   XLEN  pipeline ALU operand 1
//  ex_op2      in   XLEN  pipeline ALU operand 2
//  ex_aluop    in   4     pipeline ALU opcode
//  alu_op1     out  XLEN  to ALU op1
//  alu_op2     out  XLEN  to ALU op2
//  alu_aluop   out  4     to ALU aluop
//  alu_result  in   XLEN  from ALU (combinational)
//  busy        out  1     high in RUN and DONE
//  stall_o     out  1     pipeline stall; equals busy
//  done        out  1     one-cycle pulse, result valid
//  result      out  XLEN  product low word; held until next accepted start
// BEHAVIOUR
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  Reset (rst_n=0 at a clk edge):
//   - State goes to IDLE. acc, mcand, mplier, cnt and result clear to 0.
//   - busy, stall_o and done go to 0.
//   - Reset mid-operation aborts the multiply with no done pulse.
//  IDLE:
//   - alu_op1/alu_op2/alu_aluop = ex_op1/ex_op2/ex_aluop (pure combinational pass-through).
//   - On start=1: acc<=0, mcand<=mul_a, mplier<=mul_b, cnt<=0.
//   - Next state is RUN. If mul_b==0, next state is DONE instead.
//  RUN (one step per cycle):
//   - alu_op1=acc; alu_op2 = mplier[0] ? mcand : 0; alu_aluop=ADD_OP.
//   - Edge: acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
//   - Leave RUN for DONE after the step where cnt==XLEN-1.
//   - The adder wraps mod 2^XLEN, which gives exactly the low product word.
//  DONE (one cycle):
//   - done=1 and result=acc. The register update is visible in this same cycle.
//   - ALU ports return to pass-through. Next state is IDLE.
//  Latency: start accepted at edge E0 -> done high in the cycle after edge E0+XLEN
//   (33 cycles after start for XLEN=32). With mul_b==0: done in the cycle after E0.
//  start while busy is ignored and not queued.
//  start in the cycle done is high is also ignored; it is accepted the next cycle.
//  stall_o must be asserted in the very cycle after start is accepted.
//  No ALU command from the pipeline is issued to the ALU while busy.
//  Inputs mul_a/mul_b may change after acceptance without effect.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//   - In RUN, if the next mplier (mplier>>1) is 0 after a step, go to DONE immediately.
//   - Latency becomes 1 + (index of highest set bit of mul_b) + 1 cycles.
//   - Results are bit-identical to the build without it.
//  MUL_EARLY_EXIT_EN undefined:
//   - Always XLEN RUN steps. Latency is fixed and data-independent.
// TESTING
//  1) a=6, b=7, start 1 cycle -> busy next cycle; done after 33 cycles; result=42.
//     With EARLY_EXIT: done after 4 cycles.
//  2) a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001 (wrap).
//     a=0x80000000, b=2 -> result=0.
//  3) b=0, a=0x1234 -> done pulse in the cycle after start; result=0; no RUN cycles.
//  4) Pass-through: IDLE, ex_op1=5, ex_op2=9, ex_aluop=4'b0011 -> ALU ports equal these
//     in the same cycle. During RUN, alu_aluop=ADD_OP regardless of ex_*.
//  5) start held high for 40 cycles with a=3, b=5 -> exactly one multiply;
//     second accepted start occurs the cycle after done; result=15.
//  6) rst_n=0 at step 10 of a run -> next cycle IDLE, busy/done/result=0.
//     A new start (a=2, b=3) then completes with result=6.

Source files
------------

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Purpose:
//   A multi-cycle shift-add multiplier that borrows the EX-stage ALU adder.
//   It sits between the EX-stage operand muxes and the ALU. While idle it
//   passes the pipeline operands straight through. While multiplying it owns
//   the ALU, issues one ADD per cycle and stalls the pipeline. It produces
//   the low XLEN bits of the product (RV32 MUL semantics).
//
// Optional feature:
//   MUL_EARLY_EXIT_EN - when defined, RUN ends as soon as no multiplier bits
//   remain. Results are identical. Latency then depends on the highest set
//   bit of mul_b.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 multiply request, sampled only in IDLE
//   mul_a, mul_b          multiplicand / multiplier, captured on accepted start
//   ex_op1/ex_op2/ex_aluop  pipeline ALU command
//   alu_op1/alu_op2/alu_aluop  command driven to the ALU
//   alu_result            combinational ALU result
//   busy, stall_o         high in RUN and DONE
//   done                  one-cycle pulse when result is valid
//   result                product low word, held until the next product
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int         XLEN   = 32,
  parameter int         CNT_W  = 6,
  parameter logic [3:0] ADD_OP = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] mul_a,
  input  logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [3:0]      ex_aluop,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_aluop,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output logic            stall_o,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state, datapath and ALU-port steering.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    alu_op1   = ex_op1;
    alu_op2   = ex_op2;
    alu_aluop = ex_aluop;
    busy      = 1'b0;
    done      = 1'b0;
    result    = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = mul_a;
          mplier_d = mul_b;
          cnt_d    = '0;
          // A zero multiplier needs no add steps; the cleared acc is the answer.
          state_d  = (mul_b == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        busy      = 1'b1;
        alu_op1   = acc_q;
        alu_op2   = mplier_q[0] ? mcand_q : '0;
        alu_aluop = ADD_OP;
        acc_d     = alu_result;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
`ifdef MUL_EARLY_EXIT_EN
        // Remaining multiplier bits are all zero, so further adds contribute nothing.
        else if (mplier_d == '0) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        // result is shown combinationally so it is valid alongside the done pulse.
        busy     = 1'b1;
        done     = 1'b1;
        result   = acc_q;
        result_d = acc_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o = busy;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
// Self-checking bench for alu_mul_seq. A transaction-level model predicts
// busy/done/result and the ALU port values every cycle from plain
// arithmetic on the captured operands; directed cases pin known products
// and latencies, then randomized multiplies exercise the rest.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

  localparam int         XLEN   = 32;
  localparam logic [3:0] ADD_OP = 4'b0000;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [XLEN-1:0] mul_a, mul_b;
  logic [XLEN-1:0] ex_op1, ex_op2;
  logic [3:0]      ex_aluop;
  logic [XLEN-1:0] alu_op1, alu_op2;
  logic [3:0]      alu_aluop;
  logic [XLEN-1:0] alu_result;
  logic            busy, stall_o, done;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  alu_mul_seq #(.XLEN(XLEN), .CNT_W(6), .ADD_OP(ADD_OP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .ex_aluop   (ex_aluop),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_aluop  (alu_aluop),
    .alu_result (alu_result),
    .busy       (busy),
    .stall_o    (stall_o),
    .done       (done),
    .result     (result)
  );

  // Simple ALU stand-in: ADD for the add opcode, XOR for anything else.
  assign alu_result = (alu_aluop == ADD_OP) ? (alu_op1 + alu_op2) : (alu_op1 ^ alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit              m_pending = 1'b0;
  int              m_countdown = 0;
  int              m_step = 0;
  logic [XLEN-1:0] m_a = '0, m_b = '0, m_prod = '0, m_last = '0;

  function automatic int msbIndex(logic [XLEN-1:0] v);
    int idx = -1;
    for (int i = 0; i < XLEN; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Number of RUN cycles between acceptance and the done cycle.
  function automatic int runCycles(logic [XLEN-1:0] b);
    if (b == '0) return 0;
    if (EARLY) return msbIndex(b) + 1;
    return XLEN;
  endfunction

  task automatic checkOutput(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_last    = '0;
    end else if (!m_pending) begin
      if (start) begin
        m_pending   = 1'b1;
        m_a         = mul_a;
        m_b         = mul_b;
        m_prod      = XLEN'(64'(mul_a) * 64'(mul_b));
        m_countdown = runCycles(mul_b);
        m_step      = 0;
      end
    end else if (m_countdown == 0) begin
      m_pending = 1'b0;
      m_last    = m_prod;
    end else begin
      m_countdown--;
      m_step++;
    end
  end

  // Compare process: every cycle once reset has defined the DUT state.
  always @(negedge clk) begin
    if (check_en) begin
      automatic bit              exp_done = m_pending && (m_countdown == 0);
      automatic logic [63:0]     mask     = (64'(1) << m_step) - 64'(1);
      automatic logic [XLEN-1:0] partial  = XLEN'(64'(m_a) * (64'(m_b) & mask));
      automatic logic [XLEN-1:0] addend   = m_b[m_step % XLEN] ? (m_a << m_step) : '0;
      checkOutput("busy",    XLEN'(busy),    XLEN'(m_pending));
      checkOutput("stall_o", XLEN'(stall_o), XLEN'(m_pending));
      checkOutput("done",    XLEN'(done),    XLEN'(exp_done));
      checkOutput("result",  result,         exp_done ? m_prod : m_last);
      if (!m_pending || exp_done) begin
        checkOutput("alu_op1_pass",   alu_op1,          ex_op1);
        checkOutput("alu_op2_pass",   alu_op2,          ex_op2);
        checkOutput("alu_aluop_pass", XLEN'(alu_aluop), XLEN'(ex_aluop));
      end else begin
        checkOutput("alu_op1_run",   alu_op1,          partial);
        checkOutput("alu_op2_run",   alu_op2,          addend);
        checkOutput("alu_aluop_run", XLEN'(alu_aluop), XLEN'(ADD_OP));
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(logic s, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                               logic [XLEN-1:0] o1, logic [XLEN-1:0] o2, logic [3:0] op);
    @(posedge clk);
    #1;
    start    = s;
    mul_a    = a;
    mul_b    = b;
    ex_op1   = o1;
    ex_op2   = o2;
    ex_aluop = op;
  endtask

  task automatic randomCycle(logic s);
    applyStimulus(s, $urandom, $urandom, $urandom, $urandom, 4'($urandom));
  endtask

  // Launch a multiply from IDLE and wait for done; returns observed latency.
  task automatic runMul(logic [XLEN-1:0] a, logic [XLEN-1:0] b, bit noisy_start,
                        output int lat, output logic [XLEN-1:0] res);
    applyStimulus(1'b1, a, b, $urandom, $urandom, 4'($urandom));
    randomCycle(1'b0);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 100) begin
      randomCycle(noisy_start ? 1'($urandom_range(0, 1)) : 1'b0);
      lat++;
      @(negedge clk);
    end
    checkOutput("done_timeout", XLEN'(done), XLEN'(1));
    res = result;
    randomCycle(1'b0);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      randomCycle(1'b0);
      n++;
      @(negedge clk);
    end
    checkOutput("idle_timeout", XLEN'(busy), XLEN'(0));
  endtask

  initial begin
    int              lat;
    int              dones;
    int              exp_dones;
    int              plat;
    logic [XLEN-1:0] res, a, b;

    rst_n = 1'b0; start = 1'b0; mul_a = '0; mul_b = '0;
    ex_op1 = '0; ex_op2 = '0; ex_aluop = '0;
    @(posedge clk);
    #1 check_en = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("reset_busy",   XLEN'(busy), '0);
    checkOutput("reset_done",   XLEN'(done), '0);
    checkOutput("reset_result", result,      '0);

    // Pass-through while idle
    applyStimulus(1'b0, '0, '0, 32'd5, 32'd9, 4'b0011);
    @(negedge clk);
    checkOutput("pt_op1",   alu_op1,          32'd5);
    checkOutput("pt_op2",   alu_op2,          32'd9);
    checkOutput("pt_aluop", XLEN'(alu_aluop), 32'd3);

    // 6 * 7, with an ALU-ownership check in the first RUN cycle
    applyStimulus(1'b1, 32'd6, 32'd7, 32'd5, 32'd9, 4'b0011);
    applyStimulus(1'b0, '0, '0, 32'd5, 32'd9, 4'b0011);
    @(negedge clk);
    checkOutput("run_busy",  XLEN'(stall_o),   32'd1);
    checkOutput("run_aluop", XLEN'(alu_aluop), 32'd0);
    lat = 1;
    while (!done && lat < 100) begin
      randomCycle(1'b0);
      lat++;
      @(negedge clk);
    end
    checkOutput("mul_6x7",     result,      32'd42);
    checkOutput("lat_6x7",     XLEN'(lat),  EARLY ? 32'd4 : 32'd33);
    randomCycle(1'b0);

    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, res);
    checkOutput("mul_wrap_ff", res, 32'h0000_0001);
    runMul(32'h8000_0000, 32'd2, 1'b1, lat, res);
    checkOutput("mul_wrap_80", res, 32'h0000_0000);
    runMul(32'h1234, 32'd0, 1'b0, lat, res);
    checkOutput("mul_b0",     res,        32'd0);
    checkOutput("lat_b0",     XLEN'(lat), 32'd1);

    // start held high for 40 cycles: re-accepted only the cycle after done
    plat = EARLY ? 4 : 33;
    exp_dones = 0;
    for (int n = 0; plat + n * (plat + 1) <= 39; n++) exp_dones++;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 32'd3, 32'd5, $urandom, $urandom, 4'($urandom));
      @(negedge clk);
      if (done) begin
        dones++;
        checkOutput("held_result", result, 32'd15);
      end
    end
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    waitIdle();
    checkOutput("held_dones",  XLEN'(dones), XLEN'(exp_dones));
    checkOutput("held_final",  result,       32'd15);

    // Reset at step 10 of a run aborts it
    applyStimulus(1'b1, $urandom, 32'hFFFF_FFFF, '0, '0, '0);
    for (int c = 0; c < 10; c++) randomCycle(1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",   XLEN'(busy), '0);
    checkOutput("abort_done",   XLEN'(done), '0);
    checkOutput("abort_result", result,      '0);
    runMul(32'd2, 32'd3, 1'b0, lat, res);
    checkOutput("mul_after_abort", res, 32'd6);

    // Randomized multiplies
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = XLEN'($urandom_range(1, 255));
        2:       b = $urandom;
        default: b = XLEN'(1) << $urandom_range(0, XLEN - 1);
      endcase
      runMul(a, b, 1'b1, lat, res);
      checkOutput("rand_product", res,        XLEN'(64'(a) * 64'(b)));
      checkOutput("rand_latency", XLEN'(lat), XLEN'(runCycles(b) + 1));
    end

    repeat (2) randomCycle(1'b0);
    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
